// File: rtl/imem_pkg.sv
// ============================================================================
// Module : imem_pkg
// Brief  : Shared constants, FSM state type and load-error codes for imem_loader
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam logic [31:0] c_NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_PARTIAL  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/imem_ram.sv
// ============================================================================
// Module : imem_ram
// Brief  : Simple dual-port word RAM, synchronous write and registered read
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    // No reset on purpose: contents survive reset and map onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Instruction memory with UART program loader and CPU hold control
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] NOP_WORD = c_NOP_WORD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       pc,
    input  logic              load_mode,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [31:0]       instruction,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [1:0]        load_error,
    output logic [ADDR_W:0]   words_loaded,
    output logic              fetch_fault
);

    localparam logic [ADDR_W:0] c_ONE = (ADDR_W+1)'(1);

    state_t            r_state;
    logic              r_lm_prev;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;
    logic [ADDR_W:0]   r_word_addr;
    logic [1:0]        r_load_error;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_fetch_fault;
    logic              r_force_nop;

    logic              w_rise;
    logic              w_exit;
    logic              w_full;
    logic              w_accept;
    logic              w_we;
    logic [31:0]       w_wdata;
    logic              w_pc_fault;
    logic              w_serve;
    logic [ADDR_W-1:0] w_raddr;
    logic [31:0]       w_rdata;

    always_comb begin
        w_rise     = load_mode && !r_lm_prev;
        w_exit     = (r_state == LOAD) && !load_mode && r_lm_prev;
        w_full     = r_word_addr[ADDR_W];
        w_accept   = (r_state == LOAD) && rx_valid && !w_exit && !w_full;
        w_we       = w_accept && (r_byte_cnt == 2'd3) && !reset;
        w_wdata    = {rx_byte, r_asm};
        w_pc_fault = (pc[1:0] != 2'd0) || ((pc >> (ADDR_W + 2)) != 16'd0);
        w_serve    = (r_state == IDLE) && !w_rise;
        w_raddr    = pc[ADDR_W+1:2];
    end

    imem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (w_we),
        .waddr (r_word_addr[ADDR_W-1:0]),
        .wdata (w_wdata),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_lm_prev     <= 1'b0;
            r_byte_cnt    <= 2'd0;
            r_asm         <= 24'd0;
            r_word_addr   <= '0;
            r_load_error  <= ERR_NONE;
            r_cpu_hold    <= 1'b0;
            r_load_done   <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_force_nop   <= 1'b1;
        end else begin
            r_lm_prev   <= load_mode;
            r_load_done <= 1'b0;

            // Flags travel with the RAM's registered read data.
            if (w_serve) begin
                r_force_nop   <= w_pc_fault;
                r_fetch_fault <= w_pc_fault;
            end else begin
                r_force_nop   <= 1'b1;
                r_fetch_fault <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state      <= LOAD;
                        r_byte_cnt   <= 2'd0;
                        r_word_addr  <= '0;
                        r_load_error <= ERR_NONE;
                        r_cpu_hold   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_exit) begin
                        r_state     <= DONE;
                        r_load_done <= 1'b1;
                        if ((r_byte_cnt != 2'd0) && (r_load_error == ERR_NONE)) begin
                            r_load_error <= ERR_PARTIAL;
                        end
                    end else if (rx_valid) begin
                        if (w_full) begin
                            r_load_error <= ERR_OVERFLOW;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            case (r_byte_cnt)
                                2'd0:    r_asm[7:0]   <= rx_byte;
                                2'd1:    r_asm[15:8]  <= rx_byte;
                                2'd2:    r_asm[23:16] <= rx_byte;
                                default: r_word_addr  <= r_word_addr + c_ONE;
                            endcase
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_cpu_hold <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instruction  = r_force_nop ? NOP_WORD : w_rdata;
    assign cpu_hold     = r_cpu_hold;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;
    assign words_loaded = r_word_addr;
    assign fetch_fault  = r_fetch_fault;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Randomized self-checking bench; a large (ADDR_W=12) and a tiny
//          (ADDR_W=2) loader share stimulus and are checked against a model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [15:0] pc;
    logic        load_mode;
    logic        rx_valid;
    logic [7:0]  rx_byte;

    logic [31:0] instr [2];
    logic        hold  [2];
    logic        done  [2];
    logic [1:0]  err   [2];
    logic        fault [2];
    logic [12:0] wl_big;
    logic [2:0]  wl_small;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per instance word store plus session state.
    logic [31:0] m_mem   [2][4096];
    bit          m_ok    [2][4096];
    logic [7:0]  m_bytes [2][4];
    int          m_nb    [2];
    int          m_wl    [2];
    int          m_err   [2];

    imem_loader #(.ADDR_W(12)) u_dut_big (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .load_mode    (load_mode),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .instruction  (instr[0]),
        .cpu_hold     (hold[0]),
        .load_done    (done[0]),
        .load_error   (err[0]),
        .words_loaded (wl_big),
        .fetch_fault  (fault[0])
    );

    imem_loader #(.ADDR_W(2)) u_dut_small (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .load_mode    (load_mode),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .instruction  (instr[1]),
        .cpu_hold     (hold[1]),
        .load_done    (done[1]),
        .load_error   (err[1]),
        .words_loaded (wl_small),
        .fetch_fault  (fault[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int depth(input int k);
        return (k == 0) ? 4096 : 4;
    endfunction

    function automatic int obs_wl(input int k);
        return (k == 0) ? int'(wl_big) : int'(wl_small);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic m_begin();
        for (int k = 0; k < 2; k++) begin
            m_wl[k] = 0; m_err[k] = 0; m_nb[k] = 0;
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            if (m_wl[k] == depth(k)) begin
                m_err[k] = 1;
            end else begin
                m_bytes[k][m_nb[k]] = b;
                m_nb[k]++;
                if (m_nb[k] == 4) begin
                    m_mem[k][m_wl[k]] = {m_bytes[k][3], m_bytes[k][2], m_bytes[k][1], m_bytes[k][0]};
                    m_ok[k][m_wl[k]]  = 1'b1;
                    m_wl[k]++;
                    m_nb[k] = 0;
                end
            end
        end
    endtask

    task automatic m_end();
        for (int k = 0; k < 2; k++)
            if (m_nb[k] != 0 && m_err[k] == 0) m_err[k] = 2;
    endtask

    task automatic do_reset();
        reset = 1'b1; load_mode = 1'b0; rx_valid = 1'b0;
        tick(); tick();
        m_begin();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_instr[%0d]", k), instr[k], c_NOP);
            chk($sformatf("rst_hold[%0d]", k), 32'(hold[k]), 32'd0);
            chk($sformatf("rst_done[%0d]", k), 32'(done[k]), 32'd0);
            chk($sformatf("rst_err[%0d]", k), 32'(err[k]), 32'd0);
            chk($sformatf("rst_wl[%0d]", k), 32'(obs_wl(k)), 32'd0);
            chk($sformatf("rst_fault[%0d]", k), 32'(fault[k]), 32'd0);
        end
        reset = 1'b0;
    endtask

    task automatic check_held(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_hold[%0d]", tag, k), 32'(hold[k]), 32'd1);
            chk($sformatf("%s_instr[%0d]", tag, k), instr[k], c_NOP);
            chk($sformatf("%s_fault[%0d]", tag, k), 32'(fault[k]), 32'd0);
        end
    endtask

    task automatic start_session();
        load_mode = 1'b1;
        pc = 16'($urandom);
        tick();
        m_begin();
        check_held("start");
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("start_wl[%0d]", k), 32'(obs_wl(k)), 32'd0);
            chk($sformatf("start_err[%0d]", k), 32'(err[k]), 32'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_byte = b; pc = 16'($urandom);
        tick();
        rx_valid = 1'b0;
        m_byte(b);
        check_held("byte");
        repeat ($urandom_range(0, 2)) begin
            rx_byte = 8'($urandom);
            tick();
        end
    endtask

    task automatic end_session(input bit junk);
        load_mode = 1'b0; rx_valid = junk; rx_byte = 8'($urandom);
        tick();
        rx_valid = 1'b0;
        m_end();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("end_done[%0d]", k), 32'(done[k]), 32'd1);
            chk($sformatf("end_hold[%0d]", k), 32'(hold[k]), 32'd1);
            chk($sformatf("end_wl[%0d]", k), 32'(obs_wl(k)), 32'(m_wl[k]));
            chk($sformatf("end_err[%0d]", k), 32'(err[k]), 32'(m_err[k]));
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("idle_done[%0d]", k), 32'(done[k]), 32'd0);
            chk($sformatf("idle_hold[%0d]", k), 32'(hold[k]), 32'd0);
        end
    endtask

    task automatic do_fetch(input logic [15:0] a);
        bit f;
        pc = a;
        tick();
        for (int k = 0; k < 2; k++) begin
            f = (a[1:0] != 2'd0) || ((int'(a) >> 2) >= depth(k));
            chk($sformatf("fault@%h[%0d]", a, k), 32'(fault[k]), 32'(f));
            if (f)
                chk($sformatf("nop@%h[%0d]", a, k), instr[k], c_NOP);
            else if (m_ok[k][int'(a) >> 2])
                chk($sformatf("instr@%h[%0d]", a, k), instr[k], m_mem[k][int'(a) >> 2]);
        end
    endtask

    initial begin
        logic [7:0] prog [8];
        int n;
        prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        reset = 1'b1; pc = 16'd0; load_mode = 1'b0; rx_valid = 1'b0; rx_byte = 8'd0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) m_ok[k][i] = 1'b0;

        do_reset();
        do_fetch(16'h0000);

        // Two-word program
        start_session();
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        end_session(1'b0);
        do_fetch(16'h0000);
        chk("prog_w0", instr[0], 32'h0010_0513);
        do_fetch(16'h0004);
        chk("prog_w1", instr[0], 32'h0020_0593);

        // Partial word: word 1 keeps old contents
        start_session();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        end_session(1'b1);
        do_fetch(16'h0004);
        do_fetch(16'h0002);
        do_fetch(16'h4000);
        do_fetch(16'h3FFC);

        // 20 bytes: tiny instance overflows
        start_session();
        for (int i = 0; i < 20; i++) send_byte(8'($urandom));
        end_session(1'b0);
        for (int w = 0; w < 6; w++) do_fetch(16'(w * 4));

        // Reset in the middle of the second word
        start_session();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        do_reset();
        do_fetch(16'h0000);
        start_session();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        end_session(1'b0);
        do_fetch(16'h0000);

        // Empty session
        start_session();
        end_session(1'b0);

        for (int s = 0; s < 10; s++) begin
            start_session();
            n = $urandom_range(0, 22);
            for (int i = 0; i < n; i++) send_byte(8'($urandom));
            end_session(1'($urandom));
            for (int w = 0; w <= m_wl[0] && w < 7; w++) do_fetch(16'(w * 4));
            for (int i = 0; i < 3; i++) do_fetch(16'($urandom_range(0, 40)));
            do_fetch(16'($urandom));
            rx_valid = 1'b1; rx_byte = 8'($urandom);
            tick();
            rx_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
